// File: rtl/cpu_core_pkg.sv
// Shared types and instruction field positions for the cpu_core slice.
// Optional multiplier enabled by defining CPU_CORE_MUL_EN.
package cpu_core_pkg;

  typedef enum logic [5:0] {
    OP_NOP   = 6'd0,
    OP_ADD   = 6'd1,
    OP_SUB   = 6'd2,
    OP_AND   = 6'd3,
    OP_OR    = 6'd4,
    OP_XOR   = 6'd5,
    OP_LDI   = 6'd6,
    OP_STORE = 6'd7,
    OP_LOAD  = 6'd8,
    OP_CMPEQ = 6'd9,
    OP_CMPLT = 6'd10,
    OP_JMP   = 6'd11,
    OP_JMPF  = 6'd12,
    OP_HALT  = 6'd13,
    OP_MUL   = 6'd14
  } opcode_t;

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_EXEC,
    ST_MEM,
    ST_STOP
  } state_t;

  localparam int OP_LSB  = 0;
  localparam int OP_W    = 6;
  localparam int RS1_LSB = 6;
  localparam int RS2_LSB = 10;
  localparam int RD_LSB  = 14;
  localparam int HL_BIT  = 18;
  localparam int IMM_LSB = 32;
  localparam int IMM_W   = 32;

`ifdef CPU_CORE_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

endpackage

// File: rtl/cpu_core_if.sv
// Memory bus between cpu_core (master) and the memory model (slave).
interface cpu_core_if #(
  parameter int ADDR_W = 64
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [63:0]       mem_wdata;
  logic [63:0]       mem_rdata;
  logic              mem_ready;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                  input  mem_rdata, mem_ready);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                  output mem_rdata, mem_ready);
endinterface

// File: rtl/cpu_core_alu.sv
// Combinational datapath: arithmetic, logic, compare and (with CPU_CORE_MUL_EN) MUL.
module cpu_core_alu
  import cpu_core_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] result,
  output logic        flag
);

  always_comb begin
    result = '0;
    flag   = 1'b0;
    case (op)
      OP_ADD:   result = a + b;
      OP_SUB:   result = a - b;
      OP_AND:   result = a & b;
      OP_OR:    result = a | b;
      OP_XOR:   result = a ^ b;
`ifdef CPU_CORE_MUL_EN
      OP_MUL:   result = a * b;
`endif
      OP_CMPEQ: flag = (a == b);
      OP_CMPLT: flag = (a < b);
      default:  ;
    endcase
  end

endmodule

// File: rtl/cpu_core.sv
// Multi-cycle 64-bit core: FETCH -> EXEC [-> MEM] -> FETCH, HALT parks in STOP.
// MUL is only a defined opcode when CPU_CORE_MUL_EN is defined.
module cpu_core
  import cpu_core_pkg::*;
#(
  parameter int          NREGS    = 8,
  parameter int          ADDR_W   = 64,
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic       clock,
  input  logic       reset,
  cpu_core_if.master bus,
  output logic       halted,
  output logic       illegal
);

  localparam int IDX_W = $clog2(NREGS);

  state_t            state, next_state;
  logic [ADDR_W-1:0] pc, pc_next;
  logic [63:0]       regs [NREGS];
  logic [NREGS-1:0]  flags;

  logic [5:0]        op;
  logic [IDX_W-1:0]  rs1, rs2, rd;
  logic              hl;
  logic [IMM_W-1:0]  imm;

  logic [63:0]       rs1_val, rs2_val, alu_result;
  logic              alu_flag, op_defined;
  logic              req_c, we_c;
  logic [ADDR_W-1:0] addr_c;
  logic [63:0]       wdata_c;

  assign rs1_val = regs[rs1];
  assign rs2_val = regs[rs2];
  assign halted  = (state == ST_STOP);

  cpu_core_alu u_alu (
    .op     (op),
    .a      (rs1_val),
    .b      (rs2_val),
    .result (alu_result),
    .flag   (alu_flag)
  );

  always_comb begin
    op_defined = 1'b0;
    case (op)
      OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LDI, OP_STORE,
      OP_LOAD, OP_CMPEQ, OP_CMPLT, OP_JMP, OP_JMPF, OP_HALT: op_defined = 1'b1;
      OP_MUL:  op_defined = MUL_EN;
      default: op_defined = 1'b0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_FETCH;
    else       state <= next_state;
  end

  // Bus outputs are decoded from state, then forced low while reset is held.
  always_comb begin
    next_state = state;
    pc_next    = pc + ADDR_W'(1);
    req_c      = 1'b0;
    we_c       = 1'b0;
    addr_c     = '0;
    wdata_c    = '0;
    case (state)
      ST_FETCH: begin
        req_c  = 1'b1;
        addr_c = pc;
        if (bus.mem_ready) next_state = ST_EXEC;
      end
      ST_EXEC: begin
        if (op == OP_LOAD || op == OP_STORE) next_state = ST_MEM;
        else if (op == OP_HALT)              next_state = ST_STOP;
        else                                 next_state = ST_FETCH;
        if (op == OP_JMP || (op == OP_JMPF && flags[rs1])) pc_next = ADDR_W'(imm);
      end
      ST_MEM: begin
        req_c  = 1'b1;
        we_c   = (op == OP_STORE);
        addr_c = rs1_val[ADDR_W-1:0];
        if (op == OP_STORE) wdata_c = rs2_val;
        if (bus.mem_ready) next_state = ST_FETCH;
      end
      default: ;
    endcase
    if (reset) begin
      req_c   = 1'b0;
      we_c    = 1'b0;
      addr_c  = '0;
      wdata_c = '0;
    end
  end

  assign bus.mem_req   = req_c;
  assign bus.mem_we    = we_c;
  assign bus.mem_addr  = addr_c;
  assign bus.mem_wdata = wdata_c;

  // Only the used instruction fields are latched at fetch completion.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc      <= RESET_PC[ADDR_W-1:0];
      op      <= '0;
      rs1     <= '0;
      rs2     <= '0;
      rd      <= '0;
      hl      <= 1'b0;
      imm     <= '0;
      illegal <= 1'b0;
      flags   <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (bus.mem_ready) begin
            op  <= bus.mem_rdata[OP_LSB +: OP_W];
            rs1 <= bus.mem_rdata[RS1_LSB +: IDX_W];
            rs2 <= bus.mem_rdata[RS2_LSB +: IDX_W];
            rd  <= bus.mem_rdata[RD_LSB +: IDX_W];
            hl  <= bus.mem_rdata[HL_BIT];
            imm <= bus.mem_rdata[IMM_LSB +: IMM_W];
          end
        end
        ST_EXEC: begin
          pc <= pc_next;
          if (!op_defined) illegal <= 1'b1;
          case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: regs[rd] <= alu_result;
            OP_MUL:   if (MUL_EN) regs[rd] <= alu_result;
            OP_LDI:   regs[rd] <= hl ? {imm, regs[rd][31:0]} : 64'(imm);
            OP_CMPEQ, OP_CMPLT: flags[rd] <= alu_flag;
            default:  ;
          endcase
        end
        ST_MEM: begin
          if (bus.mem_ready && op == OP_LOAD) regs[rd] <= bus.mem_rdata;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/cpu_core.md
CPU_CORE -- requirements
Module: cpu_core
Interface
REQ-001 SHALL have parameter NREGS, default 8, general registers (2..16, power of 2), each with a 1-bit flag.
REQ-002 SHALL have parameter ADDR_W, default 64, memory word-address width (8..64).
REQ-003 SHALL have parameter RESET_PC, default 0, PC value after reset.
REQ-004 SHALL have port clock  in  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port mem_req  out  1  memory transaction request.
REQ-007 SHALL have port mem_we  out  1  1 = write, 0 = read.
REQ-008 SHALL have port mem_addr  out  ADDR_W  word address.
REQ-009 SHALL have port mem_wdata  out  64  store data.
REQ-010 SHALL have port mem_rdata  in  64  read data, valid when mem_ready is high.
REQ-011 SHALL have port mem_ready  in  1  transaction completes in any cycle where mem_req and mem_ready are both high.
REQ-012 SHALL have port halted  out  1  core stopped by HALT.
REQ-013 SHALL have port illegal  out  1  sticky flag, undefined opcode executed.
Function
REQ-014 SHALL decode the 64-bit instruction as: op[5:0], rs1[9:6], rs2[13:10], rd[17:14], hl[18], imm[63:32]; index bits at or above log2(NREGS) are ignored.
REQ-015 SHALL run the FSM FETCH->EXEC->FETCH; LOAD/STORE go EXEC->MEM->FETCH; HALT goes EXEC->STOP, and STOP is left only by reset.
REQ-016 SHALL, in FETCH, drive mem_req=1, mem_we=0, mem_addr=pc; on completion it latches mem_rdata as the instruction and moves to EXEC.
REQ-017 SHALL hold mem_addr, mem_we and mem_wdata stable while mem_req is high and mem_ready is low; mem_req=0 in EXEC and STOP.
REQ-018 SHALL execute ADD/SUB/AND/OR/XOR as rd = rs1 op rs2, 64-bit, wrapping modulo 2^64, with result written in the EXEC cycle.
REQ-019 SHALL execute LDI as: hl=0 -> rd = zero-extended imm; hl=1 -> rd = {imm, rd[31:0]}.
REQ-020 SHALL execute CMPEQ/CMPLT (unsigned) as flag[rd] = (rs1 == rs2) or (rs1 < rs2); the register value is unchanged.
REQ-021 SHALL execute LOAD as: MEM reads address rs1[ADDR_W-1:0], and rd = mem_rdata on completion.
REQ-022 SHALL execute STORE as: MEM writes rs2 to address rs1[ADDR_W-1:0].
REQ-023 SHALL set next PC: JMP -> imm zero-extended or truncated to ADDR_W; JMPF -> imm if flag[rs1] else pc+1; all others pc+1, wrapping modulo 2^ADDR_W.
REQ-024 SHALL read operands before write-back in the same cycle, so rd==rs1 uses the old value.
REQ-025 SHALL treat an undefined opcode as NOP and set illegal=1 until reset.
REQ-026 SHALL give these latencies with zero-wait memory (mem_ready tied 1): ALU/LDI/CMP/JMP = 2 cycles per instruction, LOAD/STORE = 3; each memory wait cycle adds 1.
REQ-027 SHALL write NOP as no state change except PC.
Reset
REQ-028 SHALL, on reset assertion, immediately force: state=FETCH, pc=RESET_PC, all registers and flags 0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, halted=0, illegal=0.
REQ-029 SHALL abandon an in-flight transaction on reset mid-operation, with no register write; the first request after release is a fetch from RESET_PC.
Configuration
REQ-030 SHALL, with macro CPU_CORE_MUL_EN defined, execute MUL as rd = low 64 bits of rs1*rs2 in one EXEC cycle.
REQ-031 SHALL, without CPU_CORE_MUL_EN, treat MUL as undefined per REQ-025 and instantiate no multiplier.
Structure
REQ-032 SHALL place the opcode enum (NOP=0, ADD=1, SUB=2, AND=3, OR=4, XOR=5, LDI=6, STORE=7, LOAD=8, CMPEQ=9, CMPLT=10, JMP=11, JMPF=12, HALT=13, MUL=14), the FSM state enum and the field-position constants in package cpu_core_pkg.
REQ-033 SHALL implement the combinational datapath (arith, logic, compare, MUL) in sub-module cpu_core_alu; the register file, flags, PC and FSM stay in cpu_core.
Verification
REQ-034 SHALL cover: zero-wait program LDI r1,5; LDI r2,7; ADD r3,r1,r2; HALT -> r3=12, halted=1 at cycle 8.
REQ-035 SHALL cover: mem_ready low 3 cycles during the fetch at pc=0 -> mem_addr=0 and mem_req held stable for 4 cycles, and the instruction executes once.
REQ-036 SHALL cover: STORE r1->[r2=0x10] then LOAD r4<-[0x10] -> write cycle with mem_addr=0x10, mem_wdata=5, then r4=5.
REQ-037 SHALL cover: CMPLT flag[1]=(3<4) then JMPF r1,0x20 -> next fetch address 0x20; with operands swapped -> pc+1.
REQ-038 SHALL cover: opcode 63 -> illegal=1 and registers unchanged; also MUL 6*7 -> r=42 with CPU_CORE_MUL_EN defined, and illegal=1 without it.
REQ-039 SHALL cover: reset asserted during a pending STORE -> mem_req=0 the same cycle, memory not written, and the next fetch is from RESET_PC.
